// File: rtl/fp_add_sequencer.sv
// Operand FIFO, issue FSM and result capture register around a fixed-latency FP adder.
// Latency: pop to out_valid is LATENCY+2 cycles; one pair in flight at a time.
// Backpressure: in_ready=!full; a stalled output slot holds the FSM in CAPTURE.

// Small generic FIFO: combinational head read, registered occupancy count.
module fp_add_fifo #(
  parameter int W     = 72,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               wdat,
  input  logic                       pop,
  output logic [W-1:0]               rdat,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign rdat  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Storage array carries no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdat;
  end

  // Pointer and occupancy tracking; simultaneous push/pop leaves count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module fp_add_sequencer #(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 5,
  parameter int TAG_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_a,
  input  logic [31:0]            in_b,
  output logic [31:0]            add_a,
  output logic [31:0]            add_b,
  output logic                   add_valid,
  input  logic [31:0]            add_sum,
  input  logic                   add_error,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_sum,
  output logic                   out_error,
  output logic [TAG_W-1:0]       out_tag,
  output logic [2:0]             out_class,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   busy
);
  localparam int FW = 64 + TAG_W;
  localparam int LW = $clog2(LATENCY + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_CAPTURE = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [LW-1:0]    wait_cnt;
  logic [TAG_W-1:0] tag_cnt;
  logic [TAG_W-1:0] pend_tag;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             capture;
  logic [FW-1:0]    fifo_rdat;

  // {is_nan, is_inf, is_zero}; the three cases are mutually exclusive.
  function automatic logic [2:0] fp_class(input logic [31:0] v);
    logic exp_ones;
    logic exp_zero;
    logic man_zero;
    exp_ones = (v[30:23] == 8'hFF);
    exp_zero = (v[30:23] == 8'h00);
    man_zero = (v[22:0] == 23'd0);
    return {exp_ones && !man_zero, exp_ones && man_zero, exp_zero && man_zero};
  endfunction

  // No pass-through: a full FIFO refuses input even when it pops this cycle.
  assign in_ready  = !fifo_full;
  assign push      = in_valid && !fifo_full;
  assign pop       = (state == S_IDLE) && !fifo_empty;
  assign capture   = (state == S_CAPTURE) && (!out_valid || out_ready);
  assign add_valid = (state == S_ISSUE);
  assign busy      = (state != S_IDLE);

  fp_add_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdat  ({in_a, in_b, tag_cnt}),
    .pop   (pop),
    .rdat  (fifo_rdat),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Next-state selection. WAIT leaves when the decremented count would hit 0,
  // so CAPTURE lands exactly LATENCY cycles after the ISSUE cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (!fifo_empty) state_nxt = S_ISSUE;
      S_ISSUE:   state_nxt = S_WAIT;
      S_WAIT:    if (wait_cnt == LW'(1)) state_nxt = S_CAPTURE;
      S_CAPTURE: if (capture) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Adder latency countdown, armed in ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    wait_cnt <= '0;
    else if (state == S_ISSUE)  wait_cnt <= LW'(LATENCY - 1);
    else if (state == S_WAIT)   wait_cnt <= wait_cnt - 1'b1;
  end

  // Operands and tag latched on pop; held for the whole busy period since the adder reads them late.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      add_a    <= '0;
      add_b    <= '0;
      pend_tag <= '0;
    end else if (pop) begin
      add_a    <= fifo_rdat[FW-1 -: 32];
      add_b    <= fifo_rdat[TAG_W +: 32];
      pend_tag <= fifo_rdat[TAG_W-1:0];
    end
  end

  // Sequence tag assigned at push time, wrapping naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       tag_cnt <= '0;
    else if (push) tag_cnt <= tag_cnt + 1'b1;
  end

  // Output slot: a capture in the same cycle as a consumer accept keeps out_valid high with new data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_error <= 1'b0;
      out_tag   <= '0;
      out_class <= '0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_sum   <= add_sum;
      out_error <= add_error;
      out_tag   <= pend_tag;
      out_class <= fp_class(add_sum);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fp_add_sequencer.sv
// Bench for fp_add_sequencer: scoreboard of operand pairs vs. captured results.
// The adder is modelled as garbage until LATENCY cycles after add_valid, then the real result.
// Output readiness is either fixed or randomized per cycle.
module tb_fp_add_sequencer;
  localparam int DEPTH = 4;
  localparam int LAT   = 5;
  localparam int TAG_W = 8;

  typedef struct {
    logic [31:0]      sum;
    logic             err;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [31:0] add_a, add_b, add_sum;
  logic add_valid, add_error;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [31:0] out_sum;
  logic out_error;
  logic [TAG_W-1:0] out_tag;
  logic [2:0] out_class;
  logic [$clog2(DEPTH):0] fifo_count;
  logic busy;

  int total = 0;
  int bad = 0;
  exp_t sb[$];
  logic [TAG_W-1:0] tag_m = '0;
  logic rand_rdy = 1'b0;
  logic fix_rdy = 1'b1;
  int age = 0;
  int cyc = 0;
  int av_cyc = 0;
  logic prev_av = 1'b0, prev_ov = 1'b0, prev_rdy = 1'b0;
  logic [63:0] prev_dat = '0;
  logic [31:0] snap_a = '0, snap_b = '0;
  logic [31:0] last_sum = '0;
  logic last_err = 1'b0;
  logic [TAG_W-1:0] last_tag = '0;
  logic [2:0] last_class = '0;
  logic [32:0] add_res;

  fp_add_sequencer #(.DEPTH(DEPTH), .LATENCY(LAT), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .add_a(add_a), .add_b(add_b), .add_valid(add_valid),
    .add_sum(add_sum), .add_error(add_error),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_error(out_error), .out_tag(out_tag), .out_class(out_class),
    .fifo_count(fifo_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Integer-valued float -> int (stimulus only uses small integers and specials).
  function automatic int fp2int(input logic [31:0] f);
    int e;
    int mag;
    if (f[30:23] == 8'd0) return 0;
    e = int'(f[30:23]) - 127;
    mag = int'({1'b1, f[22:0]} >> (23 - e));
    return f[31] ? -mag : mag;
  endfunction

  function automatic logic [31:0] int2fp(input int v);
    int m;
    int p;
    logic s;
    if (v == 0) return 32'd0;
    s = (v < 0);
    m = s ? -v : v;
    p = 0;
    for (int i = 0; i < 31; i++) if (m[i]) p = i;
    return {s, 8'(127 + p), 23'(m << (23 - p))};
  endfunction

  // Reference IEEE add restricted to the stimulus domain: {error, sum}.
  function automatic logic [32:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic a_nan, b_nan, a_inf, b_inf;
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) return {1'b1, 32'h7FFFFFFF};
    if (a_inf) return {1'b0, a};
    if (b_inf) return {1'b0, b};
    return {1'b0, int2fp(fp2int(a) + fp2int(b))};
  endfunction

  function automatic logic [2:0] class_of(input logic [31:0] v);
    logic nan_b, inf_b, zero_b;
    nan_b  = (v[30:23] == 8'hFF) && (v[22:0] != 0);
    inf_b  = (v[30:23] == 8'hFF) && (v[22:0] == 0);
    zero_b = (v[30:23] == 8'h00) && (v[22:0] == 0);
    return {nan_b, inf_b, zero_b};
  endfunction

  function automatic logic [31:0] rand_op();
    int r;
    int v;
    r = $urandom_range(0, 11);
    v = int'($urandom_range(0, 2000)) - 1000;
    case (r)
      0: return 32'h7F800000;
      1: return 32'hFF800000;
      2: return 32'h7FC00000;
      3: return 32'h00000000;
      default: return int2fp(v);
    endcase
  endfunction

  // Adder model: correct result only once LAT cycles have elapsed since add_valid.
  always @(posedge clk or posedge rst) begin
    if (rst)            age <= 0;
    else if (add_valid) age <= 1;
    else if (age != 0 && age < 1000) age <= age + 1;
  end
  assign add_res   = (age >= LAT) ? fp_add(add_a, add_b) : {1'b1, 32'hDEADBEEF};
  assign add_sum   = add_res[31:0];
  assign add_error = add_res[32];

  // Output readiness driver.
  always begin
    @(posedge clk);
    #1;
    out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : fix_rdy;
  end

  // Monitor and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    logic [32:0] r;
    if (rst) begin
      prev_av = 1'b0;
      prev_ov = 1'b0;
      prev_rdy = 1'b0;
    end else begin
      cyc++;
      chk("in_ready_vs_count", in_ready, fifo_count != DEPTH);
      if (in_valid && in_ready) begin
        r = fp_add(in_a, in_b);
        e.sum = r[31:0];
        e.err = r[32];
        e.tag = tag_m;
        sb.push_back(e);
        tag_m++;
      end
      if (add_valid) begin
        chk("add_valid_spacing", prev_av, 0);
        chk("add_valid_busy", busy, 1);
        snap_a = add_a;
        snap_b = add_b;
        av_cyc = cyc;
      end else if (busy) begin
        chk("hold_a", add_a, snap_a);
        chk("hold_b", add_b, snap_b);
      end
      if (out_valid && !prev_ov) chk("latency", cyc - av_cyc, LAT + 1);
      if (prev_ov && !prev_rdy) begin
        chk("out_valid_hold", out_valid, 1);
        chk("out_stable", {out_error, out_class, out_tag, out_sum}, prev_dat);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("spurious_out", out_valid, 0);
        else begin
          e = sb.pop_front();
          chk("out_sum", out_sum, e.sum);
          chk("out_error", out_error, e.err);
          chk("out_tag", out_tag, e.tag);
          chk("out_class", out_class, class_of(e.sum));
          last_sum = out_sum;
          last_err = out_error;
          last_tag = out_tag;
          last_class = out_class;
        end
      end
      prev_av = add_valid;
      prev_ov = out_valid;
      prev_rdy = out_ready;
      prev_dat = {out_error, out_class, out_tag, out_sum};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pair(input logic [31:0] a, input logic [31:0] b);
    int n;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) chk("push_timeout", in_ready, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 5000) begin
      step();
      n++;
    end
    step();
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_add_valid"}, add_valid, 0);
    chk({pfx, "_add_a"}, add_a, 0);
    chk({pfx, "_add_b"}, add_b, 0);
    chk({pfx, "_out_valid"}, out_valid, 0);
    chk({pfx, "_out_sum"}, out_sum, 0);
    chk({pfx, "_out_error"}, out_error, 0);
    chk({pfx, "_out_tag"}, out_tag, 0);
    chk({pfx, "_out_class"}, out_class, 0);
    chk({pfx, "_fifo_count"}, fifo_count, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_in_ready"}, in_ready, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    tag_m = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    #1;
    rst = 1'b0;
    step();
  endtask

  initial begin
    do_reset();

    // Basic add with a fixed-ready consumer.
    rand_rdy = 1'b0;
    fix_rdy = 1'b1;
    push_pair(32'h3F800000, 32'h40000000);
    wait_drain();
    chk("basic_sum", last_sum, 32'h40400000);
    chk("basic_err", last_err, 0);
    chk("basic_tag", last_tag, 0);
    chk("basic_class", last_class, 3'b000);

    // Infinity plus finite.
    push_pair(32'h7F800000, 32'h3F800000);
    wait_drain();
    chk("inf_sum", last_sum, 32'h7F800000);
    chk("inf_class", last_class, 3'b010);
    chk("inf_err", last_err, 0);

    // Invalid operations.
    push_pair(32'h7F800000, 32'hFF800000);
    wait_drain();
    chk("invalid_err", last_err, 1);
    chk("invalid_sum", last_sum, 32'h7FFFFFFF);
    chk("invalid_class", last_class, 3'b100);
    push_pair(32'h7FC00000, 32'h3F800000);
    wait_drain();
    chk("nan_op_err", last_err, 1);

    // Zero result.
    push_pair(32'h40000000, 32'hC0000000);
    wait_drain();
    chk("zero_class", last_class, 3'b001);

    // Full FIFO with a stalled output slot.
    do_reset();
    fix_rdy = 1'b0;
    repeat (2) step();
    for (int i = 0; i < 6; i++) push_pair(int2fp(i + 1), int2fp(10 * i));
    repeat (30) step();
    chk("full_count", fifo_count, DEPTH);
    chk("full_in_ready", in_ready, 0);
    chk("full_busy", busy, 1);
    chk("full_out_valid", out_valid, 1);
    chk("full_out_tag", out_tag, 0);
    fix_rdy = 1'b1;
    wait_drain();
    chk("full_last_tag", last_tag, 5);

    // Tag wrap with randomized operands and consumer readiness.
    do_reset();
    rand_rdy = 1'b1;
    for (int i = 0; i < 257; i++) begin
      repeat ($urandom_range(0, 2)) step();
      push_pair(rand_op(), rand_op());
    end
    wait_drain();
    chk("wrap_last_tag", last_tag, 0);

    // Reset in the middle of an operation.
    rand_rdy = 1'b0;
    fix_rdy = 1'b1;
    do_reset();
    push_pair(int2fp(3), int2fp(4));
    push_pair(int2fp(5), int2fp(6));
    push_pair(int2fp(7), int2fp(8));
    step();
    chk("midop_count", fifo_count, 2);
    chk("midop_busy", busy, 1);
    #3;
    rst = 1'b1;
    sb.delete();
    tag_m = '0;
    #1;
    check_reset_vals("midop");
    @(posedge clk);
    #2;
    rst = 1'b0;
    step();
    push_pair(int2fp(9), int2fp(1));
    wait_drain();
    chk("midop_next_tag", last_tag, 0);
    chk("midop_next_sum", last_sum, 32'h41200000);
    chk("end_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
